// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between control/execute and the multiply/divide sequencer.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] srcB;
  logic              flush;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, srcA, srcB, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared accumulator: shift-add multiply or
// restoring shift-subtract divide ({remainder, quotient} layout).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [2*DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0]   i_b,
  input  logic                i_is_div,
  output logic [2*DATA_W-1:0] o_acc_c
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_rem_sh;
  logic [DATA_W:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + {1'b0, i_b};
    w_rem_sh = i_acc[2*DATA_W-1:DATA_W-1];
    w_diff   = w_rem_sh - {1'b0, i_b};
    if (i_is_div) begin
      // Bit DATA_W of the difference set means the trial subtraction borrowed.
      if (!w_diff[DATA_W]) o_acc_c = {w_diff[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
      else                 o_acc_c = {w_rem_sh[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b0};
    end else if (i_acc[0]) begin
      o_acc_c = {w_sum, i_acc[DATA_W-1:1]};
    end else begin
      o_acc_c = {1'b0, i_acc[2*DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also services MTHI/MTLO.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int unsigned AW = 2 * DATA_W;

  logic [1:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [AW-1:0]     r_acc, w_acc_nxt;
  logic [DATA_W-1:0] r_b, w_b_nxt;
  logic              r_is_div, w_is_div_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic [DATA_W-1:0] r_hi, w_hi_nxt;
  logic [DATA_W-1:0] r_lo, w_lo_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_done_pend, w_pend_nxt;
  logic              r_dbz, w_dbz_nxt;

  logic [AW-1:0]     w_step_acc;
  logic              w_op_signed, w_op_div;
  logic              w_sign_a, w_sign_b;
  logic [DATA_W-1:0] w_abs_a, w_abs_b;
  logic [AW-1:0]     w_prod;
  logic [DATA_W-1:0] w_quo, w_rem;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .i_acc    (r_acc),
    .i_b      (r_b),
    .i_is_div (r_is_div),
    .o_acc_c  (w_step_acc)
  );

  // Operand conditioning at issue and sign correction at writeback.
  always_comb begin
    w_op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    w_op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    w_sign_a    = w_op_signed & bus.srcA[DATA_W-1];
    w_sign_b    = w_op_signed & bus.srcB[DATA_W-1];
    w_abs_a     = w_sign_a ? (-bus.srcA) : bus.srcA;
    w_abs_b     = w_sign_b ? (-bus.srcB) : bus.srcB;
    w_prod      = r_neg_q ? (-r_acc) : r_acc;
    w_quo       = r_neg_q ? (-r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
    w_rem       = r_neg_r ? (-r_acc[AW-1:DATA_W]) : r_acc[AW-1:DATA_W];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_b_nxt      = r_b;
    w_is_div_nxt = r_is_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done_pend;
    w_pend_nxt   = 1'b0;
    w_dbz_nxt    = r_dbz;
    case (r_state)
      ST_IDLE: begin
        if (!bus.flush && bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              if (w_op_div && (bus.srcB == '0)) begin
                w_dbz_nxt  = 1'b1;
                w_pend_nxt = 1'b1;
              end else begin
                w_acc_nxt    = {{DATA_W{1'b0}}, w_abs_a};
                w_b_nxt      = w_abs_b;
                w_is_div_nxt = w_op_div;
                w_neg_q_nxt  = w_sign_a ^ w_sign_b;
                w_neg_r_nxt  = w_sign_a;
                w_cnt_nxt    = '0;
                w_state_nxt  = ST_RUN;
                w_busy_nxt   = 1'b1;
                w_dbz_nxt    = 1'b0;
              end
            end
            OP_MTHI: begin
              w_hi_nxt   = bus.srcA;
              w_pend_nxt = 1'b1;
              w_dbz_nxt  = 1'b0;
            end
            OP_MTLO: begin
              w_lo_nxt   = bus.srcA;
              w_pend_nxt = 1'b1;
              w_dbz_nxt  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_acc_nxt = w_step_acc;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        if (!bus.flush) begin
          w_done_nxt = 1'b1;
          if (r_is_div) begin
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quo;
          end else begin
            w_hi_nxt = w_prod[AW-1:DATA_W];
            w_lo_nxt = w_prod[DATA_W-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_b         <= w_b_nxt;
      r_is_div    <= w_is_div_nxt;
      r_neg_q     <= w_neg_q_nxt;
      r_neg_r     <= w_neg_r_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_done_pend <= w_pend_nxt;
      r_dbz       <= w_dbz_nxt;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected HI/LO/flag,
// a done-triggered monitor pops and compares.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;
  int   n_done;

  muldiv_if #(.DATA_W(32)) bus ();

  muldiv_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_done = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with hi=0x%08h lo=0x%08h, expected no done", bus.hi, bus.lo);
      end else begin
        e = exp_q.pop_front();
        check("sb_hi", bus.hi, e.hi);
        check("sb_lo", bus.lo, e.lo);
        check("sb_dbz", 32'(bus.div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Issue one op and watch up to 45 cycles; k counts clock edges after the start edge.
  // inj_kind: 1 = pulse a MULTU start at k == inj_k, 2 = pulse flush at k == inj_k.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input int exp_busy,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input int inj_k, input int inj_kind, output logic dbz0);
    int   lat;
    int   busy_n;
    exp_t e;
    if (exp_lat >= 0) begin
      e.hi = ehi;
      e.lo = elo;
      e.dbz = edbz;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srcA  = a;
    bus.srcB  = b;
    lat    = -1;
    busy_n = 0;
    dbz0   = 1'bx;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 3'd7;
      if (k == 0) dbz0 = bus.div_by_zero;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1 && lat < 0) lat = k;
      if (k == inj_k && inj_kind == 1) begin
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.srcA  = 32'd9;
        bus.srcB  = 32'd9;
      end
      if (k == inj_k && inj_kind == 2) bus.flush = 1'b1;
    end
    check_int({name, "_latency"}, lat, exp_lat);
    check_int({name, "_busy_cycles"}, busy_n, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d0;
    int   nd;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd7;
    bus.srcA  = '0;
    bus.srcB  = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
    check("rst_hi",   bus.hi, 32'd0);
    check("rst_lo",   bus.lo, 32'd0);
    rst = 1'b1;

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 33,
           32'hFFFFFFFE, 32'h00000001, 1'b0, -1, 0, d0);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 33, 33,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1, 0, d0);
    run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 33, 33,
           32'd1, 32'd3, 1'b0, -1, 0, d0);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 33,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1, 0, d0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 33,
           32'h00000000, 32'h80000000, 1'b0, -1, 0, d0);
    run_op("mthi", OP_MTHI, 32'h12345678, 32'd0, 1, 0,
           32'h12345678, 32'h80000000, 1'b0, -1, 0, d0);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 1, 0,
           32'h12345678, 32'h80000000, 1'b1, -1, 0, d0);
    check("dbz_set_held", 32'(bus.div_by_zero), 32'd1);
    run_op("multu_2_3", OP_MULTU, 32'd2, 32'd3, 33, 33,
           32'd0, 32'd6, 1'b0, -1, 0, d0);
    check("dbz_clear_at_start", 32'(d0), 32'd0);
    run_op("divu_ign_start", OP_DIVU, 32'd100, 32'd7, 33, 33,
           32'd2, 32'd14, 1'b0, 5, 1, d0);
    run_op("divu_flush", OP_DIVU, 32'd100, 32'd7, -1, 11,
           32'd0, 32'd0, 1'b0, 10, 2, d0);
    check("flush_hi_kept", bus.hi, 32'd2);
    check("flush_lo_kept", bus.lo, 32'd14);

    // flush beats start in IDLE
    nd = n_done;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MTHI; bus.srcA = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd7;
    repeat (3) @(negedge clk);
    check_int("idle_flush_no_done", n_done, nd);
    check("idle_flush_hi_kept", bus.hi, 32'd2);

    // op 6 is a no-op
    nd = n_done;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.srcA = 32'h11111111;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd7;
    repeat (3) @(negedge clk);
    check_int("op6_no_done", n_done, nd);
    check("op6_busy", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.srcA = 32'd3; bus.srcB = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd7;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_hi", bus.hi, 32'd0);
    check("async_rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("mtlo_after_rst", OP_MTLO, 32'hA5A5A5A5, 32'd0, 1, 0,
           32'd0, 32'hA5A5A5A5, 1'b0, -1, 0, d0);

    check_int("sb_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
